// File: rtl/eth_fcs_append.sv
// Transmit-side Ethernet FCS generator: forwards a byte stream, zero-pads short
// frames to MIN_LEN bytes and appends the reflected CRC-32 FCS, LSB first.
module eth_fcs_append #(
    parameter int unsigned MIN_LEN = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       s_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_last,
    input  logic       m_ready
);

    localparam int unsigned  CW      = (MIN_LEN > 0) ? $clog2(MIN_LEN + 1) : 1;
    localparam logic [31:0]  POLY    = 32'hEDB88320;
    localparam logic [CW-1:0] CNT_MAX = CW'(MIN_LEN);

    typedef enum logic [1:0] {
        ST_DATA,
        ST_PAD,
        ST_FCS
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    crc_q, crc_d;
    logic [CW-1:0]  count_q, count_d;
    logic [1:0]     fcs_idx_q, fcs_idx_d;

    logic [31:0]    fcs;
    logic [7:0]     fcs_byte;
    logic [31:0]    cnt_plus1;
    logic [CW-1:0]  cnt_inc;

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'd0, b};
        for (int unsigned k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign fcs       = ~crc_q;
    assign cnt_plus1 = 32'(count_q) + 32'd1;
    assign cnt_inc   = (count_q == CNT_MAX) ? count_q : count_q + CW'(1);

    always_comb begin
        fcs_byte = fcs[7:0];
        case (fcs_idx_q)
            2'd0: fcs_byte = fcs[7:0];
            2'd1: fcs_byte = fcs[15:8];
            2'd2: fcs_byte = fcs[23:16];
            2'd3: fcs_byte = fcs[31:24];
            default: fcs_byte = fcs[7:0];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        count_d   = count_q;
        fcs_idx_d = fcs_idx_q;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        m_data    = '0;
        m_last    = 1'b0;

        case (state_q)
            ST_DATA: begin
                m_valid = s_valid;
                m_data  = s_data;
                s_ready = m_ready;
                if (s_valid && m_ready) begin
                    crc_d   = crc_byte(crc_q, s_data);
                    count_d = cnt_inc;
                    if (s_last) begin
                        state_d = (cnt_plus1 < MIN_LEN) ? ST_PAD : ST_FCS;
                    end
                end
            end
            ST_PAD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    crc_d   = crc_byte(crc_q, 8'h00);
                    count_d = cnt_inc;
                    if (cnt_plus1 >= MIN_LEN) begin
                        state_d = ST_FCS;
                    end
                end
            end
            ST_FCS: begin
                m_valid = 1'b1;
                m_data  = fcs_byte;
                m_last  = (fcs_idx_q == 2'd3);
                if (m_ready) begin
                    fcs_idx_d = fcs_idx_q + 2'd1;
                    if (fcs_idx_q == 2'd3) begin
                        state_d   = ST_DATA;
                        crc_d     = '1;
                        count_d   = '0;
                        fcs_idx_d = '0;
                    end
                end
            end
            default: state_d = ST_DATA;
        endcase

        // Handshakes are suppressed for the whole reset cycle, not just state.
        if (reset) begin
            s_ready = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_DATA;
            crc_q     <= '1;
            count_q   <= '0;
            fcs_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            count_q   <= count_d;
            fcs_idx_q <= fcs_idx_d;
        end
    end

endmodule

// File: tb/tb_eth_fcs_append.sv
// Scoreboard bench for eth_fcs_append: one instance without padding, one with
// MIN_LEN=60; expected beats are queued at stimulus time and popped by a monitor.
module tb_eth_fcs_append;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       sv0, sl0, sr0, mv0, ml0, mr0;
    logic [7:0] sd0, md0;
    logic       sv1, sl1, sr1, mv1, ml1, mr1;
    logic [7:0] sd1, md1;

    eth_fcs_append #(.MIN_LEN(0)) u0 (
        .clk(clk), .reset(reset),
        .s_valid(sv0), .s_data(sd0), .s_last(sl0), .s_ready(sr0),
        .m_valid(mv0), .m_data(md0), .m_last(ml0), .m_ready(mr0)
    );

    eth_fcs_append #(.MIN_LEN(60)) u60 (
        .clk(clk), .reset(reset),
        .s_valid(sv1), .s_data(sd1), .s_last(sl1), .s_ready(sr1),
        .m_valid(mv1), .m_data(md1), .m_last(ml1), .m_ready(mr1)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic        l;
        logic [15:0] n;
    } beat_t;

    beat_t       q0[$];
    beat_t       q1[$];
    logic [7:0]  pay[$];
    logic [31:0] tbl[256];
    logic [31:0] res[2];
    int          beats[2];
    int          prev_hs[2];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          rnd = 1'b0;
    bit          tight = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input bit ok, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] upd(input logic [31:0] c, input logic [7:0] b);
        logic [7:0] ix;
        ix = c[7:0] ^ b;
        return (c >> 8) ^ tbl[ix];
    endfunction

    task automatic push_exp(input int i, input logic [7:0] d, input bit l, input int n);
        beat_t b;
        b.d = d;
        b.l = l;
        b.n = 16'(n);
        if (i == 0) q0.push_back(b);
        else        q1.push_back(b);
    endtask

    // Model: pad payload to min_len, append ~crc LSB first.
    task automatic expect_frame(input int i, input int min_len);
        logic [31:0] c;
        int plen, padded, tot;
        c      = 32'hFFFFFFFF;
        plen   = pay.size();
        padded = (plen < min_len) ? min_len : plen;
        tot    = padded + 4;
        for (int k = 0; k < plen; k++) begin
            push_exp(i, pay[k], 1'b0, tot);
            c = upd(c, pay[k]);
        end
        for (int k = plen; k < padded; k++) begin
            push_exp(i, 8'h00, 1'b0, tot);
            c = upd(c, 8'h00);
        end
        c = ~c;
        for (int k = 0; k < 4; k++) push_exp(i, c[8*k +: 8], k == 3, tot);
    endtask

    // "123456789" with its well-known hand-computed FCS.
    task automatic load_and_expect_123(input int i);
        logic [7:0] f[4];
        f = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        pay.delete();
        for (int k = 0; k < 9; k++) begin
            pay.push_back(8'h31 + 8'(k));
            push_exp(i, 8'h31 + 8'(k), 1'b0, 13);
        end
        for (int k = 0; k < 4; k++) push_exp(i, f[k], k == 3, 13);
    endtask

    task automatic set_in(input int i, input logic v, input logic [7:0] d, input logic l);
        if (i == 0) begin sv0 = v; sd0 = d; sl0 = l; end
        else        begin sv1 = v; sd1 = d; sl1 = l; end
    endtask

    function automatic logic get_sr(input int i);
        return (i == 0) ? sr0 : sr1;
    endfunction

    task automatic send(input int i, input bit gaps);
        for (int k = 0; k < pay.size(); k++) begin
            bit done;
            int budget;
            done   = 1'b0;
            budget = 0;
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    set_in(i, 1'b0, 8'h00, 1'b0);
                    @(posedge clk);
                    #1;
                end
            end
            set_in(i, 1'b1, pay[k], k == pay.size() - 1);
            while (!done) begin
                @(negedge clk);
                done = get_sr(i);
                @(posedge clk);
                #1;
                budget++;
                if (!done && budget > 2000) begin
                    chk("send_timeout", 1'b0, 32'(budget), 32'd2000);
                    set_in(i, 1'b0, 8'h00, 1'b0);
                    return;
                end
            end
        end
        set_in(i, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q0.size() != 0 || q1.size() != 0) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        chk("drain", q0.size() == 0 && q1.size() == 0, 32'(q0.size() + q1.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic mon(input int i, input logic v, input logic r, input logic [7:0] d, input logic l);
        beat_t h;
        int n;
        if (!v) return;
        n = (i == 0) ? q0.size() : q1.size();
        if (n == 0) begin
            chk($sformatf("unexpected_beat_dut%0d", i), 1'b0, {24'd0, d}, 32'd0);
            return;
        end
        h = (i == 0) ? q0[0] : q1[0];
        chk($sformatf("m_data_dut%0d", i), d == h.d, {24'd0, d}, {24'd0, h.d});
        chk($sformatf("m_last_dut%0d", i), l == h.l, {31'd0, l}, {31'd0, h.l});
        if (!r) return;
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        res[i] = upd(res[i], d);
        beats[i]++;
        if (tight && prev_hs[i] >= 0)
            chk($sformatf("back_to_back_dut%0d", i), cyc == prev_hs[i] + 1, 32'(cyc), 32'(prev_hs[i] + 1));
        prev_hs[i] = cyc;
        if (h.l) begin
            chk($sformatf("residue_dut%0d", i), ~res[i] == 32'h2144DF1C, ~res[i], 32'h2144DF1C);
            chk($sformatf("beats_dut%0d", i), beats[i] == int'(h.n), 32'(beats[i]), 32'(h.n));
            res[i]   = 32'hFFFFFFFF;
            beats[i] = 0;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            mon(0, mv0, mr0, md0, ml0);
            mon(1, mv1, mr1, md1, ml1);
        end
    end

    always begin
        @(posedge clk);
        #1;
        mr0 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        mr1 = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    initial begin
        for (int n = 0; n < 256; n++) begin
            logic [31:0] c;
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            tbl[n] = c;
        end
        for (int i = 0; i < 2; i++) begin
            res[i] = 32'hFFFFFFFF; beats[i] = 0; prev_hs[i] = -1;
        end
        mr0 = 1'b1;
        mr1 = 1'b1;
        reset = 1'b1;
        set_in(0, 1'b1, 8'h55, 1'b1);
        set_in(1, 1'b1, 8'h55, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_s_ready_dut0", sr0 == 1'b0, {31'd0, sr0}, 32'd0);
        chk("reset_m_valid_dut0", mv0 == 1'b0, {31'd0, mv0}, 32'd0);
        chk("reset_m_last_dut0",  ml0 == 1'b0, {31'd0, ml0}, 32'd0);
        chk("reset_s_ready_dut1", sr1 == 1'b0, {31'd0, sr1}, 32'd0);
        chk("reset_m_valid_dut1", mv1 == 1'b0, {31'd0, mv1}, 32'd0);
        chk("reset_m_last_dut1",  ml1 == 1'b0, {31'd0, ml1}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(0, 1'b0, 8'h00, 1'b0);
        set_in(1, 1'b0, 8'h00, 1'b0);

        // No padding: "123456789" alone, then twice back to back.
        tight = 1'b1;
        prev_hs[0] = -1;
        load_and_expect_123(0);
        send(0, 1'b0);
        drain();
        prev_hs[0] = -1;
        for (int f = 0; f < 2; f++) begin
            load_and_expect_123(0);
            send(0, 1'b0);
        end
        drain();

        // MIN_LEN=60 boundaries, back to back with m_ready held high.
        prev_hs[1] = -1;
        for (int f = 0; f < 5; f++) begin
            int len;
            case (f)
                0: len = 1;
                1: len = 60;
                2: len = 100;
                3: len = 59;
                default: len = 61;
            endcase
            pay.delete();
            for (int k = 0; k < len; k++) begin
                if (f == 0)      pay.push_back(8'hAB);
                else if (f == 1) pay.push_back(8'(k));
                else             pay.push_back(8'(k * 3 + 1));
            end
            expect_frame(1, 60);
            send(1, 1'b0);
        end
        drain();

        // Random backpressure and source gaps.
        tight = 1'b0;
        rnd = 1'b1;
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 200);
            pay.delete();
            for (int k = 0; k < len; k++) pay.push_back(8'($urandom_range(0, 255)));
            expect_frame(1, 60);
            send(1, 1'b1);
        end
        for (int f = 0; f < 5; f++) begin
            int len;
            len = $urandom_range(1, 30);
            pay.delete();
            for (int k = 0; k < len; k++) pay.push_back(8'($urandom_range(0, 255)));
            expect_frame(0, 0);
            send(0, 1'b1);
        end
        drain();
        rnd = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // One-cycle reset while the third FCS byte is on the output.
        load_and_expect_123(0);
        send(0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("midreset_s_ready", sr0 == 1'b0, {31'd0, sr0}, 32'd0);
        chk("midreset_m_valid", mv0 == 1'b0, {31'd0, mv0}, 32'd0);
        chk("midreset_left",    q0.size() == 2, 32'(q0.size()), 32'd2);
        q0.delete();
        res[0]   = 32'hFFFFFFFF;
        beats[0] = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        load_and_expect_123(0);
        send(0, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
